// File: rtl/remote_pkg.sv
// Shared definitions for the remote-control link (transmitter and RemoteController).
package remote_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam logic        LEAD_LEVEL = 1'b0;
  localparam logic        IDLE_LEVEL = 1'b1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLead = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StStop = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [15:0] custom,
                                                        input logic [7:0]  key);
    return {custom, key, ~key};
  endfunction

endpackage

// File: rtl/remote_transmitter_if.sv
// Request/line bundle between a frame source and the remote transmitter.
interface remote_transmitter_if;
  logic [7:0] Tecla;
  logic       Send;
  logic       Serial;
  logic       Busy;
  logic       Done;

  modport master (output Tecla, Send, input Serial, Busy, Done);
  modport slave  (input Tecla, Send, output Serial, Busy, Done);
endinterface

// File: rtl/remote_tx_shifter.sv
// 32-bit load/shift-left frame register exposing its MSB and a count of bits shifted out.
module remote_tx_shifter
  import remote_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  msb,
  output logic [5:0]            count
);

  logic [FRAME_BITS-1:0] data_q;
  logic [5:0]            count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= frame;
      count_q <= '0;
    end else if (shift) begin
      data_q  <= {data_q[FRAME_BITS-2:0], 1'b0};
      count_q <= count_q + 6'd1;
    end
  end

  assign msb   = data_q[FRAME_BITS-1];
  assign count = count_q;

endmodule

// File: rtl/remote_transmitter.sv
// Remote-control frame transmitter: lead 0, {custom, key, ~key} MSB first, then a guard gap.
// Build option REMOTE_TX_AUTOREPEAT_EN: a held Send re-sends the last key after each gap.
module remote_transmitter
  import remote_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE = 16'hFFFF,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input logic                 Clock,
  input logic                 Reset,
  remote_transmitter_if.slave bus
);

  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic       send_q;
  logic       serial_q, busy_q, done_q;
  logic       accept, load, shift, msb;
  logic [5:0] bit_cnt;
  logic [7:0] key_sel;

`ifdef REMOTE_TX_AUTOREPEAT_EN
  logic       held_q;
  logic [7:0] key_q;

  // held_q marks Send continuously high since the last accepted frame.
  assign accept  = (state_q == StIdle) && bus.Send && (!send_q || held_q);
  assign key_sel = held_q ? key_q : bus.Tecla;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      held_q <= 1'b0;
      key_q  <= '0;
    end else begin
      held_q <= bus.Send && (held_q || accept);
      if (accept) key_q <= key_sel;
    end
  end
`else
  assign accept  = (state_q == StIdle) && bus.Send && !send_q;
  assign key_sel = bus.Tecla;
`endif

  remote_tx_shifter u_shifter (
    .clk   (Clock),
    .rst_n (Reset),
    .load  (load),
    .shift (shift),
    .frame (build_frame(CUSTOM_CODE, key_sel)),
    .msb   (msb),
    .count (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          load    = 1'b1;
          state_d = StLead;
        end
      end
      StLead: state_d = StData;
      StData: begin
        shift = 1'b1;
        if (bit_cnt == 6'(FRAME_BITS - 1)) state_d = StStop;
      end
      StStop: begin
        gap_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      send_q   <= 1'b0;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      send_q   <= bus.Send;
      busy_q   <= (state_q != StIdle);
      done_q   <= (state_q == StStop);
      serial_q <= (state_q == StLead) ? LEAD_LEVEL :
                  (state_q == StData) ? msb        : IDLE_LEVEL;
    end
  end

  assign bus.Serial = serial_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule

// File: doc/remote_transmitter.md
Name: remote_transmitter

Overview:
Serial transmitter for the remote-control frame format that RemoteController decodes. It is the other end of the same one-wire link.
- Frame: one lead bit (0), then 32 data bits MSB first: {custom code[15:0], key[7:0], ~key[7:0]}, then line idle at 1.
- One bit per Clock cycle, so the output drives RemoteController.Serial directly. It is used as the remote model in loopback benches and as the emitter on the board.

Parameters:
- CUSTOM_CODE, 16'hFFFF, custom/address field sent in bits 31..16.
- GAP_CYCLES, 8, idle-high cycles enforced after each frame before a new Send is accepted; legal range 1..255.

Ports:
- Clock  input  1  system clock (304 kHz nominal).
- Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Tecla  input  8  key code to transmit; sampled only when a Send is accepted.
- Send  input  1  transmit request.
- Serial  output  1  serial line; idle 1; registered.
- Busy  output  1  high while a frame or gap is in progress; Send is ignored while high.
- Done  output  1  one-cycle pulse when the last data bit has been sent.

Behaviour:
- Reset (Reset==0 at a posedge):
  - Serial=1, Busy=0, Done=0.
  - State IDLE, counters cleared, latched frame cleared.
  - Reset applied mid-frame aborts the frame. The line is back at 1 on the cycle after reset is sampled.
- States: IDLE, LEAD, DATA, STOP, GAP.
- IDLE:
  - Serial=1, Busy=0.
  - Accept a request at posedge T when Send==1 and Send was 0 on the previous edge (rising-edge detect; Send_q resets to 0).
  - On accept, latch {CUSTOM_CODE, Tecla, ~Tecla} into a 32-bit shift register and go to LEAD.
- Timing relative to acceptance edge T (values valid after each edge):
  - T+1: Serial=0 (lead bit), Busy=1.
  - T+2..T+33: Serial = frame bit 31 down to bit 0, one bit per cycle. A 6-bit counter counts 0..31.
  - T+34 (STOP): Serial=1 and Done=1 for this cycle only.
  - T+35..T+34+GAP_CYCLES (GAP): Serial=1, Busy=1. An 8-bit gap counter runs to GAP_CYCLES-1.
  - T+35+GAP_CYCLES: IDLE, Busy=0. A Send rising edge on this edge is accepted.
- Tecla changes after T do not affect the frame in flight.
- Send rising edges while Busy=1 are ignored and not queued. Send_q keeps tracking, so a level held through the end of the frame does not retrigger.
- Serial never glitches. It is driven from a flop, and the LEAD/STOP values are registered.
- Done and a new acceptance can never occur in the same cycle, because GAP_CYCLES≥1.

Optional Feature:
- Macro REMOTE_TX_AUTOREPEAT_EN.
- Defined:
  - In IDLE, Send==1 (level, not edge) with Send continuously high since the previous acceptance starts a new frame.
  - The new frame reuses the previously latched key, ignoring the current Tecla. This models a held button.
  - The first press still needs a rising edge.
- Not defined: edge-only acceptance as above. Holding Send yields exactly one frame.

Decomposition:
- Package remote_pkg holds:
  - FRAME_BITS=32, LEAD_LEVEL=1'b0, IDLE_LEVEL=1'b1.
  - State encoding (IDLE, LEAD, DATA, STOP, GAP).
  - Function build_frame(custom, key) returning {custom, key, ~key}.
- RemoteController should import the same package.
- One sub-module, remote_tx_shifter: 32-bit load/shift-left register with serial MSB output and bit counter, driven by load/shift strobes from the FSM.

Test Plan:
1. Tecla=8'h1A, Send pulse at T → Serial sequence from T+1: 0, sixteen 1s, 00011010, 11100101, then 1. Done at T+34 only. Busy falls at T+43 (GAP_CYCLES=8).
2. Loopback into RemoteController, keys 00,01,1A,B2,FF,55,AA,C3 in turn → each frame gives Ready=1 with Tecla equal to the key sent. No extra Ready pulses.
3. Tecla=8'h55 sent; a second Send edge at T+10 with Tecla=8'hAA → ignored. Frame carries 55/AA. Busy stays 1 with no second frame.
4. Reset driven low at T+15 mid-frame, held for 2 cycles → Serial=1, Busy=0, Done=0 on the next edge. No Done pulse. The receiver shows no Ready. A new Send afterwards produces a clean full frame.
5. Send held high for 200 cycles with Tecla=8'hC3:
   - Without REMOTE_TX_AUTOREPEAT_EN → exactly one frame.
   - With it → frames start at T, T+35+GAP_CYCLES, …, all carrying C3/3C.
6. Tecla changed from 8'h01 to 8'hFF at T+5 → transmitted key field is still 01, complement FE.
